// File: rtl/hit_pkg.sv
// Shared definitions for the hit/ring measurement path: state encoding and default widths.
package hit_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ARM  = ST_ARM,
    S_HIT  = ST_HIT,
    S_LOCK = ST_LOCK
  } state_t;

endpackage

// File: rtl/hit_ctrl_if.sv
// Sample stream, configuration, host command and ring-counter control/status bundle of one channel.
interface hit_ctrl_if import hit_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);

  logic [DW-1:0] sm_data;
  logic          sm_vld;
  logic          cfg_en;
  logic [DW-1:0] cfg_th_start;
  logic [DW-1:0] cfg_th_stop;
  logic [CW-1:0] cfg_holdoff;
  logic [CW-1:0] cfg_win_max;
  logic [CW-1:0] cfg_lock_len;
  logic          cmd_abort;
  logic          now_hit;
  logic          now_lock;
  logic          force_end;
  logic [1:0]    stu_state;
  logic [CW-1:0] stu_hit_cnt;
  logic [CW-1:0] stu_abort_cnt;
  logic [CW-1:0] hit_len;
  logic          hit_len_vld;

  modport master (
    input  sm_data, sm_vld, cfg_en, cfg_th_start, cfg_th_stop,
           cfg_holdoff, cfg_win_max, cfg_lock_len, cmd_abort,
    output now_hit, now_lock, force_end, stu_state,
           stu_hit_cnt, stu_abort_cnt, hit_len, hit_len_vld
  );

  modport slave (
    output sm_data, sm_vld, cfg_en, cfg_th_start, cfg_th_stop,
           cfg_holdoff, cfg_win_max, cfg_lock_len, cmd_abort,
    input  now_hit, now_lock, force_end, stu_state,
           stu_hit_cnt, stu_abort_cnt, hit_len, hit_len_vld
  );

endinterface

// File: rtl/hit_timer.sv
// Single counter reused for holdoff, hit duration and lock, since those phases never overlap.
module hit_timer import hit_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld1,
  input  logic          inc,
  input  logic [CW-1:0] cmp,
  output logic [CW-1:0] cnt,
  output logic          eq
);

  always_ff @(posedge clk_sys) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (ld1) begin
      cnt <= CW'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign eq = (cnt == cmp);

endmodule

// File: rtl/hit_ctrl.sv
// Hit/lock sequencer driving now_hit, now_lock and force_end of the ring counter, plus status counters.
module hit_ctrl import hit_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input logic        clk_sys,
  input logic        rst,
  hit_ctrl_if.master bus
);

  state_t        st, st_nxt;
  logic [DW-1:0] sample;
  logic [CW-1:0] t_cnt, t_cmp;
  logic          t_eq, t_clr, t_ld1, t_inc;
  logic          start_seen, stop_seen, armed, timeout;
  logic          fe_nxt, done_nxt;
  logic          now_hit_q, now_lock_q, force_end_q, hit_len_vld_q;
  logic [CW-1:0] hit_cnt_q, abort_cnt_q, hit_len_q;

  assign sample     = bus.sm_data;
  assign start_seen = bus.sm_vld && (sample >= bus.cfg_th_start);
  assign stop_seen  = bus.sm_vld && (sample <  bus.cfg_th_stop);
  assign armed      = (t_cnt >= bus.cfg_holdoff);
  assign timeout    = (bus.cfg_win_max != '0) && t_eq;
  assign t_cmp      = (st == S_LOCK) ? bus.cfg_lock_len : bus.cfg_win_max;

  hit_timer #(.CW(CW)) u_timer (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr     (t_clr),
    .ld1     (t_ld1),
    .inc     (t_inc),
    .cmp     (t_cmp),
    .cnt     (t_cnt),
    .eq      (t_eq)
  );

  always_comb begin
    st_nxt   = st;
    t_clr    = 1'b0;
    t_ld1    = 1'b0;
    t_inc    = 1'b0;
    fe_nxt   = 1'b0;
    done_nxt = 1'b0;
    case (st)
      S_IDLE: begin
        t_clr = 1'b1;
        if (bus.cfg_en) st_nxt = S_ARM;
      end
      S_ARM: begin
        if (!bus.cfg_en) begin
          st_nxt = S_IDLE;
          t_clr  = 1'b1;
        end else if (start_seen) begin
          // An early start crossing restarts the holdoff run instead of opening a window.
          if (armed) begin
            st_nxt = S_HIT;
            t_ld1  = 1'b1;
          end else begin
            t_clr = 1'b1;
          end
        end else if (bus.sm_vld) begin
          t_inc = 1'b1;
        end
      end
      S_HIT: begin
        if (!bus.cfg_en) begin
          st_nxt = S_IDLE;
          fe_nxt = 1'b1;
          t_clr  = 1'b1;
        end else if (bus.cmd_abort || timeout) begin
          st_nxt = S_ARM;
          fe_nxt = 1'b1;
          t_clr  = 1'b1;
        end else if (stop_seen) begin
          done_nxt = 1'b1;
          if (bus.cfg_lock_len == '0) begin
            st_nxt = S_ARM;
            t_clr  = 1'b1;
          end else begin
            st_nxt = S_LOCK;
            t_ld1  = 1'b1;
          end
        end else begin
          t_inc = 1'b1;
        end
      end
      S_LOCK: begin
        if (!bus.cfg_en) begin
          st_nxt = S_IDLE;
          fe_nxt = 1'b1;
          t_clr  = 1'b1;
        end else if (bus.cmd_abort) begin
          st_nxt = S_ARM;
          fe_nxt = 1'b1;
          t_clr  = 1'b1;
        end else if (t_eq) begin
          st_nxt = S_ARM;
          t_clr  = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      st            <= S_IDLE;
      now_hit_q     <= 1'b0;
      now_lock_q    <= 1'b0;
      force_end_q   <= 1'b0;
      hit_len_vld_q <= 1'b0;
      hit_len_q     <= '0;
      hit_cnt_q     <= '0;
      abort_cnt_q   <= '0;
    end else begin
      st            <= st_nxt;
      now_hit_q     <= (st_nxt == S_HIT);
      now_lock_q    <= (st_nxt == S_LOCK);
      force_end_q   <= fe_nxt;
      hit_len_vld_q <= done_nxt;
      if (done_nxt) begin
        hit_len_q <= t_cnt;
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      if (fe_nxt) abort_cnt_q <= abort_cnt_q + 1'b1;
    end
  end

  assign bus.now_hit       = now_hit_q;
  assign bus.now_lock      = now_lock_q;
  assign bus.force_end     = force_end_q;
  assign bus.stu_state     = st;
  assign bus.stu_hit_cnt   = hit_cnt_q;
  assign bus.stu_abort_cnt = abort_cnt_q;
  assign bus.hit_len       = hit_len_q;
  assign bus.hit_len_vld   = hit_len_vld_q;

endmodule

// File: tb/tb_hit_ctrl.sv
// Bench for hit_ctrl: directed scenarios with fixed expectations, then randomized traffic against a behavioural model.
module tb_hit_ctrl;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int SAT = (1 << CW) - 1;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  hit_ctrl_if #(.DW(DW), .CW(CW)) bus ();

  hit_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Model state: phase number, consecutive-low run, hit duration, lock cycles remaining.
  int   m_phase = 0, m_run = 0, m_dur = 0, m_left = 0;
  int   m_len = 0, m_hcnt = 0, m_acnt = 0;
  logic m_fe = 1'b0, m_lenv = 1'b0;

  task automatic model_step();
    int d, ths, thp, hold, win, lock;
    d    = int'(bus.sm_data);
    ths  = int'(bus.cfg_th_start);
    thp  = int'(bus.cfg_th_stop);
    hold = int'(bus.cfg_holdoff);
    win  = int'(bus.cfg_win_max);
    lock = int'(bus.cfg_lock_len);
    m_fe   = 1'b0;
    m_lenv = 1'b0;
    if (rst) begin
      m_phase = 0; m_run = 0; m_dur = 0; m_left = 0;
      m_len = 0; m_hcnt = 0; m_acnt = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.cfg_en) begin m_phase = 1; m_run = 0; end
        end
        1: begin
          if (!bus.cfg_en) m_phase = 0;
          else if (bus.sm_vld) begin
            if (d >= ths) begin
              if (m_run >= hold) begin m_phase = 2; m_dur = 1; end
              else m_run = 0;
            end else if (m_run < SAT) m_run++;
          end
        end
        2: begin
          if (!bus.cfg_en || bus.cmd_abort || (win != 0 && m_dur == win)) begin
            m_fe = 1'b1; m_acnt = (m_acnt + 1) & SAT;
            m_phase = bus.cfg_en ? 1 : 0; m_run = 0;
          end else if (bus.sm_vld && d < thp) begin
            m_lenv = 1'b1; m_len = m_dur; m_hcnt = (m_hcnt + 1) & SAT; m_run = 0;
            if (lock == 0) m_phase = 1;
            else begin m_phase = 3; m_left = lock; end
          end else if (m_dur < SAT) m_dur++;
        end
        default: begin
          if (!bus.cfg_en || bus.cmd_abort) begin
            m_fe = 1'b1; m_acnt = (m_acnt + 1) & SAT;
            m_phase = bus.cfg_en ? 1 : 0; m_run = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin m_phase = 1; m_run = 0; end
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic send(input logic v, input int d);
    bus.sm_vld  = v;
    bus.sm_data = DW'(d);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if ({bus.now_hit, bus.now_lock, bus.force_end, bus.hit_len_vld} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got %b, expected 0000", {bus.now_hit, bus.now_lock, bus.force_end, bus.hit_len_vld});
    end else n_pass++;
    n_total++;
    if ({bus.stu_hit_cnt, bus.stu_abort_cnt, bus.hit_len} !== '0) begin
      $display("FAIL reset_cnt: got %0d/%0d/%0d, expected 0/0/0", bus.stu_hit_cnt, bus.stu_abort_cnt, bus.hit_len);
    end else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (bus.stu_state !== 2'd0) $display("FAIL reset_state: got %0d, expected 0", bus.stu_state);
    else n_pass++;
  endtask

  task automatic test_holdoff();
    int hb = 0;
    bus.cfg_en = 1'b1;
    tick();
    n_total++;
    if (bus.stu_state !== 2'd1) $display("FAIL holdoff_arm: got state %0d, expected 1", bus.stu_state);
    else n_pass++;
    send(1'b1, 50);  if (bus.now_hit) hb++;
    send(1'b1, 50);  if (bus.now_hit) hb++;
    send(1'b1, 150); if (bus.now_hit) hb++;
    send(1'b1, 50);  if (bus.now_hit) hb++;
    send(1'b1, 50);  if (bus.now_hit) hb++;
    send(1'b1, 50);  if (bus.now_hit) hb++;
    n_total++;
    if (hb != 0) $display("FAIL holdoff_early: got %0d hit cycles, expected 0", hb);
    else n_pass++;
    send(1'b1, 150);
    n_total++;
    if ({bus.now_hit, bus.stu_state} !== 3'b110) begin
      $display("FAIL holdoff_start: got hit=%b state=%0d, expected hit=1 state=2", bus.now_hit, bus.stu_state);
    end else n_pass++;
  endtask

  task automatic test_normal_hit();
    int hits = 0, lv = 0, lc;
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 120);
      if (bus.now_hit) hits++;
      if (bus.hit_len_vld) lv++;
    end
    n_total++;
    if (hits != 9 || lv != 0) $display("FAIL hit_body: got hits=%0d vld=%0d, expected 9/0", hits, lv);
    else n_pass++;
    send(1'b1, 60);
    n_total++;
    if ({bus.now_hit, bus.now_lock, bus.hit_len_vld} !== 3'b011) begin
      $display("FAIL hit_end: got %b, expected 011", {bus.now_hit, bus.now_lock, bus.hit_len_vld});
    end else n_pass++;
    n_total++;
    if (bus.hit_len !== CW'(10) || bus.stu_hit_cnt !== CW'(1)) begin
      $display("FAIL hit_len: got len=%0d cnt=%0d, expected 10/1", bus.hit_len, bus.stu_hit_cnt);
    end else n_pass++;
    lc = 1;
    lv = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 0);
      if (bus.now_lock) lc++;
      if (bus.hit_len_vld) lv++;
    end
    n_total++;
    if (lc != 4 || lv != 0) $display("FAIL lock_len: got lock=%0d vld=%0d, expected 4/0", lc, lv);
    else n_pass++;
    n_total++;
    if ({bus.now_lock, bus.stu_state} !== 3'b001) begin
      $display("FAIL lock_exit: got lock=%b state=%0d, expected 0/1", bus.now_lock, bus.stu_state);
    end else n_pass++;
  endtask

  task automatic test_timeout();
    int hits = 0, fes = 0, lv = 0, fall_fe = 0;
    logic prev = 1'b0;
    bus.cfg_win_max = CW'(8);
    send(1'b1, 50);
    send(1'b1, 50);
    send(1'b1, 50);
    for (int i = 0; i < 14; i++) begin
      send(1'b1, 200);
      if (bus.now_hit) hits++;
      if (bus.force_end) fes++;
      if (bus.hit_len_vld) lv++;
      if (prev && !bus.now_hit && bus.force_end) fall_fe++;
      prev = bus.now_hit;
    end
    n_total++;
    if (hits != 8 || fes != 1 || fall_fe != 1 || lv != 0) begin
      $display("FAIL timeout: got hit=%0d fe=%0d fe_on_fall=%0d vld=%0d, expected 8/1/1/0", hits, fes, fall_fe, lv);
    end else n_pass++;
    n_total++;
    if (bus.stu_state !== 2'd1 || bus.stu_abort_cnt !== CW'(1) || bus.stu_hit_cnt !== CW'(1)) begin
      $display("FAIL timeout_stat: got state=%0d abort=%0d hits=%0d, expected 1/1/1", bus.stu_state, bus.stu_abort_cnt, bus.stu_hit_cnt);
    end else n_pass++;
  endtask

  task automatic test_abort();
    bus.cfg_win_max = '0;
    bus.cfg_holdoff = '0;
    send(1'b1, 150);
    send(1'b1, 60);
    send(1'b0, 0);
    send(1'b0, 0);
    n_total++;
    if (bus.now_lock !== 1'b1) $display("FAIL abort_lock3: got lock=%b, expected 1", bus.now_lock);
    else n_pass++;
    bus.cmd_abort = 1'b1;
    send(1'b0, 0);
    bus.cmd_abort = 1'b0;
    n_total++;
    if ({bus.now_lock, bus.force_end, bus.now_hit, bus.stu_state} !== 5'b01001 || bus.stu_abort_cnt !== CW'(2)) begin
      $display("FAIL abort_lock: got lock=%b fe=%b hit=%b state=%0d abort=%0d, expected 0/1/0/1/2",
               bus.now_lock, bus.force_end, bus.now_hit, bus.stu_state, bus.stu_abort_cnt);
    end else n_pass++;
    send(1'b0, 0);
    n_total++;
    if (bus.force_end !== 1'b0) $display("FAIL abort_pulse: got fe=%b, expected 0", bus.force_end);
    else n_pass++;
    bus.cmd_abort = 1'b1;
    send(1'b0, 0);
    bus.cmd_abort = 1'b0;
    n_total++;
    if (bus.force_end !== 1'b0 || bus.stu_state !== 2'd1 || bus.stu_abort_cnt !== CW'(2)) begin
      $display("FAIL abort_arm: got fe=%b state=%0d abort=%0d, expected 0/1/2", bus.force_end, bus.stu_state, bus.stu_abort_cnt);
    end else n_pass++;
  endtask

  task automatic test_disable();
    send(1'b1, 150);
    send(1'b1, 120);
    bus.cfg_en = 1'b0;
    send(1'b1, 120);
    n_total++;
    if ({bus.now_hit, bus.force_end, bus.stu_state} !== 4'b0100 || bus.stu_abort_cnt !== CW'(3)) begin
      $display("FAIL disable_hit: got hit=%b fe=%b state=%0d abort=%0d, expected 0/1/0/3",
               bus.now_hit, bus.force_end, bus.stu_state, bus.stu_abort_cnt);
    end else n_pass++;
    send(1'b0, 0);
    n_total++;
    if (bus.force_end !== 1'b0) $display("FAIL disable_pulse: got fe=%b, expected 0", bus.force_end);
    else n_pass++;
    bus.cfg_en       = 1'b1;
    bus.cfg_lock_len = '0;
    send(1'b0, 0);
    send(1'b1, 150);
    send(1'b1, 60);
    n_total++;
    if ({bus.now_hit, bus.now_lock, bus.hit_len_vld, bus.stu_state} !== 5'b00101) begin
      $display("FAIL nolock_end: got hit=%b lock=%b vld=%b state=%0d, expected 0/0/1/1",
               bus.now_hit, bus.now_lock, bus.hit_len_vld, bus.stu_state);
    end else n_pass++;
    n_total++;
    if (bus.hit_len !== CW'(1) || bus.stu_hit_cnt !== CW'(3)) begin
      $display("FAIL nolock_len: got len=%0d cnt=%0d, expected 1/3", bus.hit_len, bus.stu_hit_cnt);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_hit();
    send(1'b1, 150);
    n_total++;
    if (bus.now_hit !== 1'b1) $display("FAIL rst_pre: got hit=%b, expected 1", bus.now_hit);
    else n_pass++;
    rst = 1'b1;
    send(1'b1, 120);
    n_total++;
    if ({bus.now_hit, bus.now_lock, bus.force_end, bus.hit_len_vld, bus.stu_state} !== 6'b0 ||
        {bus.stu_hit_cnt, bus.stu_abort_cnt, bus.hit_len} !== '0) begin
      $display("FAIL rst_mid: got hit=%b fe=%b state=%0d hits=%0d abort=%0d len=%0d, expected all 0",
               bus.now_hit, bus.force_end, bus.stu_state, bus.stu_hit_cnt, bus.stu_abort_cnt, bus.hit_len);
    end else n_pass++;
    rst = 1'b0;
    send(1'b0, 0);
  endtask

  task automatic test_random();
    logic [5:0]      exp_v, got_v;
    logic [3*CW-1:0] exp_c, got_c;
    for (int seg = 0; seg < 6; seg++) begin
      bus.cfg_en    = 1'b0;
      bus.cmd_abort = 1'b0;
      bus.sm_vld    = 1'b0;
      tick();
      tick();
      bus.cfg_holdoff  = CW'($urandom_range(0, 3));
      bus.cfg_win_max  = CW'($urandom_range(0, 12));
      bus.cfg_lock_len = CW'($urandom_range(0, 5));
      bus.cfg_en       = 1'b1;
      for (int c = 0; c < 250; c++) begin
        bus.sm_vld    = ($urandom_range(0, 3) != 0);
        bus.sm_data   = DW'($urandom_range(0, 200));
        bus.cmd_abort = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 199) == 0) bus.cfg_en = 1'b0;
        else if (!bus.cfg_en && $urandom_range(0, 3) == 0) bus.cfg_en = 1'b1;
        tick();
        exp_v = {m_phase == 2, m_phase == 3, m_fe, m_lenv, 2'(m_phase)};
        got_v = {bus.now_hit, bus.now_lock, bus.force_end, bus.hit_len_vld, bus.stu_state};
        n_total++;
        if (got_v !== exp_v) $display("FAIL rand_ctrl seg %0d cyc %0d: got %b, expected %b", seg, c, got_v, exp_v);
        else n_pass++;
        exp_c = {CW'(m_len), CW'(m_hcnt), CW'(m_acnt)};
        got_c = {bus.hit_len, bus.stu_hit_cnt, bus.stu_abort_cnt};
        n_total++;
        if (got_c !== exp_c) $display("FAIL rand_stat seg %0d cyc %0d: got %h, expected %h", seg, c, got_c, exp_c);
        else n_pass++;
      end
    end
    bus.cmd_abort = 1'b0;
  endtask

  initial begin
    bus.sm_data      = '0;
    bus.sm_vld       = 1'b0;
    bus.cfg_en       = 1'b0;
    bus.cfg_th_start = DW'(100);
    bus.cfg_th_stop  = DW'(80);
    bus.cfg_holdoff  = CW'(3);
    bus.cfg_win_max  = '0;
    bus.cfg_lock_len = CW'(4);
    bus.cmd_abort    = 1'b0;
    test_reset();
    test_holdoff();
    test_normal_hit();
    test_timeout();
    test_abort();
    test_disable();
    test_reset_mid_hit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary within time limit, expected completion");
    $fatal(1);
  end

endmodule
